// File: rtl/counter_cmd_arbiter_pkg.sv
// counter_arb_pkg: shared constants and types for counter_cmd_arbiter.
//   - default channel count, counter width and prescaler width
//   - pending-flag bit positions inside a per-channel flag vector
//   - signed service delta type and a helper that derives it from the flags
package counter_arb_pkg;

  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DIV_W_DEF = 24;

  // Pending-flag bit positions
  localparam int unsigned P_RST   = 0;
  localparam int unsigned P_UP    = 1;
  localparam int unsigned P_DN    = 2;
  localparam int unsigned P_AUTO  = 3;
  localparam int unsigned N_FLAGS = 4;

  typedef logic [N_FLAGS-1:0] flags_t;
  typedef logic signed [2:0]  delta_t;

  // delta = up + auto - down, range -1..+2
  function automatic delta_t flags_delta(input flags_t f);
    delta_t d;
    d = '0;
    if (f[P_UP])   d = d + 3'sd1;
    if (f[P_AUTO]) d = d + 3'sd1;
    if (f[P_DN])   d = d - 3'sd1;
    return d;
  endfunction

endpackage

// File: rtl/counter_cmd_arbiter_if.sv
// counter_cmd_arbiter_if: command/status bundle of counter_cmd_arbiter.
//   Host -> counter block : enable, div_load, auto_en, reset_req, up_req, down_req
//   Counter block -> host : count, eq_zero_pulse, eq_max_pulse, overrun, busy
//   master modport = host side, slave modport = counter block.
interface counter_cmd_arbiter_if
  import counter_arb_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
);

  logic                  enable;
  logic [DIV_W-1:0]      div_load;
  logic [N_CH-1:0]       auto_en;
  logic [N_CH-1:0]       reset_req;
  logic [N_CH-1:0]       up_req;
  logic [N_CH-1:0]       down_req;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       eq_zero_pulse;
  logic [N_CH-1:0]       eq_max_pulse;
  logic [N_CH-1:0]       overrun;
  logic                  busy;

  modport master (
    output enable, div_load, auto_en, reset_req, up_req, down_req,
    input  count, eq_zero_pulse, eq_max_pulse, overrun, busy
  );

  modport slave (
    input  enable, div_load, auto_en, reset_req, up_req, down_req,
    output count, eq_zero_pulse, eq_max_pulse, overrun, busy
  );

endinterface

// File: rtl/counter_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   [N]     request vector
//   ptr   [PTR_W] highest-priority index this cycle
//   grant [N]     one-hot grant: first requester at or above ptr, with wrap
//   valid         any request present
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] pick;

  // Requests at or above ptr win; if none, wrap to the lowest requester.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (PTR_W'(i) >= ptr);
    end
    pick  = ((req & hi_mask) != '0) ? (req & hi_mask) : req;
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i] && !valid) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter: N_CH up/down counters sharing one add/sub datapath.
//   sys_clk    sole clock
//   sys_rst_n  asynchronous active-low reset
//   bus        counter_cmd_arbiter_if.slave (commands in, counts/events out)
// Command pulses and prescaler ticks latch per-channel pending flags; a
// round-robin arbiter services one channel per cycle, updating its count
// and emitting eq_zero/eq_max event pulses. overrun flags merged requests.
// Build option: define COUNTER_SAT_EN to saturate instead of wrapping.
module counter_cmd_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  counter_cmd_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  tick;
  flags_t                pend_q [N_CH];
  flags_t                pend_d [N_CH];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [N_CH*WIDTH-1:0] count_q, count_d;
  logic [N_CH-1:0]       eq_zero_q, eq_zero_d;
  logic [N_CH-1:0]       eq_max_q, eq_max_d;
  logic [N_CH-1:0]       overrun_q, overrun_d;

  logic [N_CH-1:0]       pend_any;
  logic [N_CH-1:0]       grant;
  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  flags_t                grant_flags;
  logic [WIDTH-1:0]      cur_cnt;
  logic [WIDTH-1:0]      result;
  delta_t                delta;
`ifdef COUNTER_SAT_EN
  logic signed [WIDTH+1:0] sum;
`endif

  // Prescaler: reloads while disabled so a fresh enable ticks after div_load+1.
  always_comb begin
    tick = bus.enable && (div_cnt_q == '0);
    if (!bus.enable || tick) div_cnt_d = bus.div_load;
    else                     div_cnt_d = div_cnt_q - 1'b1;
  end

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      pend_any[c] = |pend_q[c];
    end
  end

  rr_arbiter #(
    .N     (N_CH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (pend_any),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .valid (grant_vld)
  );

  // Select the granted channel's flags and count for the shared datapath.
  always_comb begin
    grant_idx   = '0;
    grant_flags = '0;
    cur_cnt     = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (grant[c]) begin
        grant_idx   = PTR_W'(c);
        grant_flags = pend_q[c];
        cur_cnt     = count_q[c*WIDTH +: WIDTH];
      end
    end
  end

  // Shared add/sub datapath
  always_comb begin
    delta = flags_delta(grant_flags);
`ifdef COUNTER_SAT_EN
    sum = $signed({2'b00, cur_cnt}) + $signed({{(WIDTH-1){delta[2]}}, delta});
    if (sum[WIDTH+1])  result = '0;
    else if (sum[WIDTH]) result = CNT_MAX;
    else               result = sum[WIDTH-1:0];
`else
    result = cur_cnt + $unsigned(WIDTH'(delta));
`endif
    if (grant_flags[P_RST]) result = '0;
  end

  // Flag update: the granted channel is cleared before new requests merge,
  // so a same-cycle request re-arms it without counting as an overrun.
  always_comb begin
    flags_t inc;
    count_d   = count_q;
    eq_zero_d = '0;
    eq_max_d  = '0;
    overrun_d = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      inc         = '0;
      inc[P_RST]  = bus.reset_req[c];
      inc[P_UP]   = bus.up_req[c];
      inc[P_DN]   = bus.down_req[c];
      inc[P_AUTO] = tick && bus.auto_en[c];
      pend_d[c]    = (grant[c] ? flags_t'('0) : pend_q[c]) | inc;
      overrun_d[c] = !grant[c] && ((pend_q[c] & inc) != '0);
      if (grant[c]) begin
        count_d[c*WIDTH +: WIDTH] = result;
        eq_zero_d[c] = (result == '0);
        eq_max_d[c]  = (result == CNT_MAX);
      end
    end
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q <= '0;
      rr_ptr_q  <= '0;
      count_q   <= '0;
      eq_zero_q <= '0;
      eq_max_q  <= '0;
      overrun_q <= '0;
      for (int unsigned c = 0; c < N_CH; c++) pend_q[c] <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      eq_zero_q <= eq_zero_d;
      eq_max_q  <= eq_max_d;
      overrun_q <= overrun_d;
      for (int unsigned c = 0; c < N_CH; c++) pend_q[c] <= pend_d[c];
    end
  end

  assign bus.count         = count_q;
  assign bus.eq_zero_pulse = eq_zero_q;
  assign bus.eq_max_pulse  = eq_max_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = |pend_any;

endmodule

// File: doc/counter_cmd_arbiter.md
Name: counter_cmd_arbiter

Overview:
Owns N_CH up/down counters that share one add/sub datapath. It takes host reset, up and down command pulses (decoded from trigger-in endpoints) and prescaler auto-count ticks. Pending commands are latched per channel, and a round-robin arbiter services one channel per cycle. Counter values go to wire-outs; terminal-value event pulses go to trigger-outs.

Parameters:
N_CH, 4, number of counter channels
WIDTH, 8, counter width in bits
DIV_W, 24, prescaler width

Ports:
sys_clk  in  1  sole clock
sys_rst_n  in  1  asynchronous active-low reset
enable  in  1  prescaler run enable
div_load  in  DIV_W  prescaler reload; tick period = div_load+1 cycles
auto_en  in  N_CH  per-channel auto-count enable
reset_req  in  N_CH  single-cycle reset command pulses
up_req  in  N_CH  single-cycle increment pulses
down_req  in  N_CH  single-cycle decrement pulses
count  out  N_CH*WIDTH  counter values, channel i at [i*WIDTH +: WIDTH]
eq_zero_pulse  out  N_CH  1-cycle pulse: serviced result == 0
eq_max_pulse  out  N_CH  1-cycle pulse: serviced result == all ones
overrun  out  N_CH  1-cycle pulse: request lost (merged into an already-pending flag)
busy  out  1  any pending flag set

Behaviour:
- Reset (asynchronous, any time, including mid-service):
  - count, all pending flags, RR pointer, div_cnt, and all pulse outputs clear to 0.
  - busy = 0.
- Prescaler:
  - enable=0: div_cnt <= div_load, no ticks.
  - enable=1: if div_cnt==0, tick and div_cnt <= div_load; else div_cnt decrements.
  - div_load changes take effect at the next reload. div_load=0 ticks every cycle.
- Pending flags per channel: P_RST, P_UP, P_DN, P_AUTO.
  - A request pulse sampled at edge k sets its flag after edge k.
  - A tick sets P_AUTO for every channel with auto_en=1.
- Arbitration:
  - Combinational grant on pending flags: first channel with any flag set, searching upward from rr_ptr with wrap.
  - Grant at edge k+1 updates count and clears all of that channel's flags.
  - rr_ptr <= granted+1 mod N_CH. No grant leaves rr_ptr unchanged.
  - Latency is 1 cycle uncontended; worst case N_CH cycles.
- Service (one channel per cycle):
  - P_RST set: result = 0; up/down/auto are discarded.
  - Otherwise: delta = P_UP + P_AUTO - P_DN (range -1..+2, signed WIDTH+2 arithmetic); result = count + delta mod 2^WIDTH.
  - delta = 0 still consumes the grant.
- Event pulses (granted channel only, same edge as the count update):
  - eq_zero_pulse if result==0.
  - eq_max_pulse if result==2^WIDTH-1.
- Request arriving in the same cycle its channel is granted:
  - Its flag is set after the edge, not cleared, and is serviced next round. No overrun.
- Overrun: pulses for a channel when an incoming request or tick hits a flag already set on a channel not granted that cycle.
- busy = OR of all pending flags (registered flag state).

Optional Feature:
COUNTER_SAT_EN
- Defined: result saturates instead of wrapping.
  - count + delta > max clamps to max.
  - count + delta < 0 clamps to 0.
  - Event pulses are evaluated on the clamped result.
- Undefined: modulo 2^WIDTH wrap as above.

Decomposition:
- Package counter_arb_pkg:
  - pending-flag index constants (P_RST=0, P_UP=1, P_DN=2, P_AUTO=3)
  - default WIDTH/N_CH/DIV_W
  - delta type (signed 3-bit)
- Sub-module rr_arbiter: N-bit request vector plus pointer in; one-hot grant plus valid out; parameterised on N.
- Prescaler, flags, and datapath stay in counter_cmd_arbiter.

Test Plan:
- Test 1: up_req[1] pulse, idle, count[1]=0 -> count[1]=1 one edge later; busy high exactly 1 cycle.
- Test 2: up_req=4'b1111 same cycle -> counts 0,1,2,3 update on 4 consecutive edges in order ch0..ch3; busy 4 cycles.
- Test 3: count[2]=0xFE, up_req[2] with tick pending, auto_en[2]=1 -> count[2]=0x00 with eq_zero_pulse[2]. With COUNTER_SAT_EN -> 0xFF with eq_max_pulse[2].
- Test 4: count[0]=0x55, reset_req[0] and up_req[0] same cycle -> 0x00 with eq_zero_pulse[0]. Up discarded, no overrun.
- Test 5: enable=1, div_load=3, auto_en=4'b0001 -> count[0] +1 every 4 cycles. Then div_load=0, auto_en=4'b1111 -> every channel +1 per 4 cycles with overrun pulses every cycle.
- Test 6: sys_rst_n low mid-contention with busy=1 -> all outputs 0 immediately. After release, no stale grants; first service after a new request only.
